mem_access: RTL and testbench

//  Memory-access stage that sits directly downstream of the EX/MEM pipeline register.
//  - Consumes the registered load/store request and the register-writeback fields.
//  - Runs the data-bus request/ack handshake and performs byte-lane steering and load extension.
//  - Drives the final register-file write port.
//  - Stalls the front of the pipeline through ctrl while a bus access is outstanding.

---
 rtl/mem_access.sv | 189 ++++++++++++++++++
 tb/tb_mem_access.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: data-bus handshake, byte-lane steering, load extension and regfile writeback.
// Define MEM_TIMEOUT_EN to abort bus accesses that see no ack within TIMEOUT_CYCLES cycles.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        hold_flag_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        misalign_o,
  output logic        err_o
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state;
  logic        lat_we;
  logic        lat_unsigned;
  logic        lat_reg_we;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic [4:0]  lat_waddr;

  logic        aligned;
  logic        rd_nonzero;
  logic [31:0] st_wdata;
  logic [3:0]  st_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic        timeout;

  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_timeout_cfg
    $error("mem_access: TIMEOUT_CYCLES does not fit in TO_W bits");
  end

  always_comb begin
    aligned = 1'b1;
    case (mem_size_i)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~mem_addr_i[0];
      default: aligned = (mem_addr_i[1:0] == 2'b00);
    endcase
  end

  assign rd_nonzero  = (reg_waddr_i != 5'd0);
  assign hold_flag_o = (state == BUS) | ((state == IDLE) & mem_req_i & aligned);

  always_comb begin
    st_wdata = mem_wdata_i;
    st_sel   = 4'b1111;
    case (mem_size_i)
      2'b00: begin
        st_wdata = {4{mem_wdata_i[7:0]}};
        st_sel   = 4'b0001 << mem_addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{mem_wdata_i[15:0]}};
        st_sel   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Lane selection and extension use the latched offset, since the inputs are don't-care in BUS.
  always_comb begin
    ld_byte = bus_rdata_i[7:0];
    case (lat_off)
      2'd0: ld_byte = bus_rdata_i[7:0];
      2'd1: ld_byte = bus_rdata_i[15:8];
      2'd2: ld_byte = bus_rdata_i[23:16];
      2'd3: ld_byte = bus_rdata_i[31:24];
    endcase
    ld_half   = lat_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    load_data = bus_rdata_i;
    case (lat_size)
      2'b00:   load_data = lat_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_data = lat_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = bus_rdata_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // The abort fires in the BUS cycle that would make the count reach TIMEOUT_CYCLES; an ack then still wins.
  assign timeout = (state == BUS) && !bus_ack_i && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (!bus_ack_i) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      bus_sel_o    <= '0;
      reg_we_o     <= 1'b0;
      reg_waddr_o  <= '0;
      reg_wdata_o  <= '0;
      misalign_o   <= 1'b0;
      err_o        <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_reg_we   <= 1'b0;
      lat_off      <= '0;
      lat_size     <= '0;
      lat_waddr    <= '0;
    end else begin
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
      reg_we_o   <= 1'b0;
      case (state)
        IDLE: begin
          reg_waddr_o <= reg_waddr_i;
          if (mem_req_i && aligned) begin
            state        <= BUS;
            bus_req_o    <= 1'b1;
            bus_we_o     <= mem_we_i;
            bus_addr_o   <= {mem_addr_i[31:2], 2'b00};
            bus_wdata_o  <= st_wdata;
            bus_sel_o    <= st_sel;
            lat_we       <= mem_we_i;
            lat_unsigned <= mem_unsigned_i;
            lat_reg_we   <= reg_we_i & ~mem_we_i & rd_nonzero;
            lat_off      <= mem_addr_i[1:0];
            lat_size     <= mem_size_i;
            lat_waddr    <= reg_waddr_i;
            reg_wdata_o  <= '0;
          end else if (mem_req_i) begin
            misalign_o  <= 1'b1;
            reg_we_o    <= reg_we_i & ~mem_we_i & rd_nonzero;
            reg_wdata_o <= '0;
          end else begin
            reg_we_o    <= reg_we_i & rd_nonzero;
            reg_wdata_o <= reg_wdata_i;
          end
        end
        BUS: begin
          if (bus_ack_i || timeout) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_sel_o   <= '0;
            reg_we_o    <= lat_reg_we;
            reg_waddr_o <= lat_waddr;
            reg_wdata_o <= (bus_ack_i && !lat_we) ? load_data : 32'd0;
            err_o       <= timeout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed, table-driven bench for mem_access acting as the bus slave and EX/MEM driver.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_we_i, mem_unsigned_i, reg_we_i, bus_ack_i;
  logic [31:0] mem_addr_i, mem_wdata_i, reg_wdata_i, bus_rdata_i;
  logic [1:0]  mem_size_i;
  logic [4:0]  reg_waddr_i;
  logic        bus_req_o, bus_we_o, hold_flag_o, reg_we_o, misalign_o, err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, reg_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  reg_waddr_o;

  int total = 0;
  int bad   = 0;

`ifdef MEM_TIMEOUT_EN
  localparam int MAXD = 3;
`else
  localparam int MAXD = 5;
`endif

  mem_access #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .hold_flag_o(hold_flag_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .misalign_o(misalign_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, we, uns, rwe;
    logic [31:0] addr, wdata, alu, rdata;
    logic [1:0]  size;
    logic [4:0]  rd;
    int          delay;
    logic        bus;
    logic [31:0] baddr, bwdata;
    logic [3:0]  sel;
    logic        erwe;
    logic [31:0] erdata;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                              input logic rwe, input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] rdata, input int delay, input logic bus,
                              input logic [31:0] baddr, input logic [31:0] bwdata,
                              input logic [3:0] sel, input logic erwe, input logic [31:0] erdata,
                              input logic mis);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.rwe = rwe; v.rd = rd; v.alu = alu; v.rdata = rdata; v.delay = delay; v.bus = bus;
    v.baddr = baddr; v.bwdata = bwdata; v.sel = sel; v.erwe = erwe; v.erdata = erdata;
    v.mis = mis;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    mem_size_i = 2'b10; mem_unsigned_i = 1'b0; reg_we_i = 1'b0; reg_waddr_i = '0;
    reg_wdata_i = '0;
  endtask

  // Runs one instruction from the IDLE state, acking after v.delay wait cycles, then checks writeback.
  task automatic applyStimulus(input vec_t v, input string tag);
    int holds;
    mem_req_i = v.req; mem_we_i = v.we; mem_addr_i = v.addr; mem_wdata_i = v.wdata;
    mem_size_i = v.size; mem_unsigned_i = v.uns; reg_we_i = v.rwe; reg_waddr_i = v.rd;
    reg_wdata_i = v.alu; bus_ack_i = 1'b0;
    #1;
    holds = hold_flag_o ? 1 : 0;
    checkOutput({tag, " hold"}, 32'(hold_flag_o), 32'(v.bus));
    @(posedge clk); #1;
    if (v.bus) begin
      checkOutput({tag, " bus_req"}, 32'(bus_req_o), 32'd1);
      checkOutput({tag, " bus_addr"}, bus_addr_o, v.baddr);
      checkOutput({tag, " bus_we"}, 32'(bus_we_o), 32'(v.we));
      if (v.we) begin
        checkOutput({tag, " bus_sel"}, 32'(bus_sel_o), 32'(v.sel));
        checkOutput({tag, " bus_wdata"}, bus_wdata_o, v.bwdata);
      end
      for (int i = 0; i < v.delay; i++) begin
        if (hold_flag_o) holds++;
        checkOutput({tag, " wait bus_req"}, 32'(bus_req_o), 32'd1);
        checkOutput({tag, " wait bus_addr"}, bus_addr_o, v.baddr);
        checkOutput({tag, " wait reg_we"}, 32'(reg_we_o), 32'd0);
        @(posedge clk); #1;
      end
      if (hold_flag_o) holds++;
      bus_ack_i = 1'b1; bus_rdata_i = v.rdata;
      @(posedge clk); #1;
      bus_ack_i = 1'b0; bus_rdata_i = 32'h5A5A_5A5A;
      checkOutput({tag, " hold cycles"}, 32'(holds), 32'(v.delay + 2));
    end
    driveIdle();
    checkOutput({tag, " wb bus_req"}, 32'(bus_req_o), 32'd0);
    checkOutput({tag, " reg_we"}, 32'(reg_we_o), 32'(v.erwe));
    checkOutput({tag, " misalign"}, 32'(misalign_o), 32'(v.mis));
    checkOutput({tag, " err"}, 32'(err_o), 32'd0);
    if (v.erwe) begin
      checkOutput({tag, " reg_waddr"}, 32'(reg_waddr_o), 32'(v.rd));
      checkOutput({tag, " reg_wdata"}, reg_wdata_o, v.erdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [31:0] model [16];
    int op, idx, off;
    logic [31:0] d;
    logic [4:0] rd;
    logic rwe;

    driveIdle();
    bus_ack_i = 1'b0; bus_rdata_i = '0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("reset bus_we", 32'(bus_we_o), 32'd0);
    checkOutput("reset bus_addr", bus_addr_o, 32'd0);
    checkOutput("reset bus_wdata", bus_wdata_o, 32'd0);
    checkOutput("reset bus_sel", 32'(bus_sel_o), 32'd0);
    checkOutput("reset hold", 32'(hold_flag_o), 32'd0);
    checkOutput("reset reg_we", 32'(reg_we_o), 32'd0);
    checkOutput("reset reg_waddr", 32'(reg_waddr_o), 32'd0);
    checkOutput("reset reg_wdata", reg_wdata_o, 32'd0);
    checkOutput("reset misalign", 32'(misalign_o), 32'd0);
    checkOutput("reset err", 32'(err_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    //           req we  addr          wdata         sz    uns rwe rd     alu           rdata         dly bus baddr         bwdata        sel      erwe erdata        mis
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,        2'b10, 0, 1, 5'd5,  32'hDEAD_BEEF, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0,    1, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,        2'b10, 0, 1, 5'd0,  32'h0000_1234, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h103,      32'h0,        2'b00, 0, 1, 5'd3,  32'h0,        32'h80FF_FF00, 2, 1, 32'h100,      32'h0,        4'h0,    1, 32'hFFFF_FF80, 0));
    vecs.push_back(mk(1, 0, 32'h103,      32'h0,        2'b00, 1, 1, 5'd4,  32'h0,        32'h80FF_FF00, 2, 1, 32'h100,      32'h0,        4'h0,    1, 32'h0000_0080, 0));
    vecs.push_back(mk(1, 1, 32'h202,      32'h1234_ABCD, 2'b01, 0, 1, 5'd7,  32'h0,        32'h0,        0, 1, 32'h200,      32'hABCD_ABCD, 4'b1100, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h105,      32'h0,        2'b10, 0, 1, 5'd9,  32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0,    1, 32'h0,         1));
    vecs.push_back(mk(0, 0, 32'h0,        32'h0,        2'b10, 0, 1, 5'd0,  32'hFFFF_FFFF, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0,         0));
    vecs.push_back(mk(1, 1, 32'h301,      32'h0000_00A5, 2'b00, 0, 0, 5'd0,  32'h0,        32'h0,        1, 1, 32'h300,      32'hA5A5_A5A5, 4'b0010, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h406,      32'h0,        2'b01, 0, 1, 5'd10, 32'h0,        32'h8001_7FFF, 0, 1, 32'h404,      32'h0,        4'h0,    1, 32'hFFFF_8001, 0));
    vecs.push_back(mk(1, 0, 32'h404,      32'h0,        2'b01, 1, 1, 5'd11, 32'h0,        32'hFFFF_9234, 1, 1, 32'h404,      32'h0,        4'h0,    1, 32'h0000_9234, 0));
    vecs.push_back(mk(1, 0, 32'h500,      32'h0,        2'b10, 0, 1, 5'd12, 32'h0,        32'hCAFE_F00D, 3, 1, 32'h500,      32'h0,        4'h0,    1, 32'hCAFE_F00D, 0));
    vecs.push_back(mk(1, 1, 32'h600,      32'h1122_3344, 2'b10, 0, 0, 5'd0,  32'h0,        32'h0,        0, 1, 32'h600,      32'h1122_3344, 4'b1111, 0, 32'h0,         0));
    vecs.push_back(mk(1, 1, 32'h203,      32'h0000_BEEF, 2'b01, 0, 0, 5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0,    0, 32'h0,         1));
    vecs.push_back(mk(1, 0, 32'h101,      32'h0,        2'b00, 0, 1, 5'd13, 32'h0,        32'h1234_7F56, 0, 1, 32'h100,      32'h0,        4'h0,    1, 32'h0000_007F, 0));
    vecs.push_back(mk(1, 0, 32'h700,      32'h0,        2'b11, 0, 1, 5'd14, 32'h0,        32'h0BAD_BEEF, 1, 1, 32'h700,      32'h0,        4'h0,    1, 32'h0BAD_BEEF, 0));
    vecs.push_back(mk(1, 0, 32'h800,      32'h0,        2'b10, 0, 1, 5'd0,  32'h0,        32'h7777_7777, 0, 1, 32'h800,      32'h0,        4'h0,    0, 32'h0,         0));

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-BUS drops the request and writes nothing; a later stray ack is ignored.
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h900; mem_size_i = 2'b10;
    reg_we_i = 1'b1; reg_waddr_i = 5'd6;
    @(posedge clk); #1;
    driveIdle();
    checkOutput("rstbus bus_req before", 32'(bus_req_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstbus bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("rstbus reg_we", 32'(reg_we_o), 32'd0);
    checkOutput("rstbus hold", 32'(hold_flag_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1357_9BDF;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    checkOutput("stray ack reg_we", 32'(reg_we_o), 32'd0);
    checkOutput("stray ack bus_req", 32'(bus_req_o), 32'd0);
    applyStimulus(mk(0, 0, 32'h0, 32'h0, 2'b10, 0, 1, 5'd21, 32'h0000_0042, 32'h0, 0, 0,
                     32'h0, 32'h0, 4'h0, 1, 32'h0000_0042, 0), "after reset alu");

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'hA00; mem_size_i = 2'b10;
      reg_we_i = 1'b1; reg_waddr_i = 5'd15;
      @(posedge clk); #1;
      driveIdle();
      n = 0;
      while (bus_req_o && n < 20) begin
        n++;
        @(posedge clk); #1;
      end
      checkOutput("timeout req cycles", 32'(n), 32'd4);
      checkOutput("timeout err", 32'(err_o), 32'd1);
      checkOutput("timeout reg_we", 32'(reg_we_o), 32'd1);
      checkOutput("timeout reg_waddr", 32'(reg_waddr_o), 32'd15);
      checkOutput("timeout reg_wdata", reg_wdata_o, 32'd0);
      @(posedge clk); #1;
      checkOutput("timeout err pulse", 32'(err_o), 32'd0);
      checkOutput("timeout reg_we pulse", 32'(reg_we_o), 32'd0);
    end
    applyStimulus(mk(1, 0, 32'hA04, 32'h0, 2'b10, 0, 1, 5'd16, 32'h0, 32'h2468_ACE0, 2, 1,
                     32'hA04, 32'h0, 4'h0, 1, 32'h2468_ACE0, 0), "post timeout lw");
`else
    applyStimulus(mk(1, 0, 32'hB00, 32'h0, 2'b10, 0, 1, 5'd17, 32'h0, 32'h1357_9BDF, 12, 1,
                     32'hB00, 32'h0, 4'h0, 1, 32'h1357_9BDF, 0), "long wait lw");
`endif

    // Back-to-back LW/SW/SB/ALU stream against a reference word memory.
    for (int i = 0; i < 16; i++) model[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
    for (int k = 0; k < 40; k++) begin
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 15));
      off = int'($urandom_range(0, 3));
      d   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      rwe = 1'($urandom_range(0, 1));
      case (op)
        0: v = mk(0, 0, 32'h0, 32'h0, 2'b10, 0, rwe, rd, d, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0,
                  rwe && (rd != 5'd0), d, 0);
        1: v = mk(1, 0, 32'h1000 + 32'(idx * 4), 32'h0, 2'b10, 0, 1, rd, 32'h0, model[idx],
                  int'($urandom_range(0, MAXD)), 1, 32'h1000 + 32'(idx * 4), 32'h0, 4'h0,
                  rd != 5'd0, model[idx], 0);
        2: begin
          v = mk(1, 1, 32'h1000 + 32'(idx * 4), d, 2'b10, 0, rwe, rd, 32'h0, 32'h0,
                 int'($urandom_range(0, MAXD)), 1, 32'h1000 + 32'(idx * 4), d, 4'b1111, 0, 32'h0, 0);
          model[idx] = d;
        end
        default: begin
          v = mk(1, 1, 32'h1000 + 32'(idx * 4 + off), d, 2'b00, 0, rwe, rd, 32'h0, 32'h0,
                 int'($urandom_range(0, MAXD)), 1, 32'h1000 + 32'(idx * 4), {4{d[7:0]}},
                 4'(4'b0001 << off), 0, 32'h0, 0);
          model[idx][8*off +: 8] = d[7:0];
        end
      endcase
      applyStimulus(v, $sformatf("rand%0d op%0d", k, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
